// File: rtl/hls_deadlock_monitor_param.sv
// Per-region deadlock monitor: combines child monitor blocks and own stream channels,
// filters transient stalls through a persistence FSM and keeps sticky/source/duration reports.
module hls_deadlock_monitor_param #(
   parameter int                           NUM_SUB        = 2,
   parameter int                           NUM_AXIS       = 8,
   parameter int                           NUM_IDLE       = 19,
   parameter int                           NUM_INST       = 11,
   parameter logic [NUM_SUB*NUM_AXIS-1:0]  SUB_AXIS_MASK  = '0,
   parameter logic [NUM_AXIS-1:0]          CUR_AXIS_MASK  = '0,
   parameter int                           PERSIST_CYCLES = 16,
   parameter int                           CNT_W          = 8,
   parameter int                           CYC_W          = 32,
   parameter int                           SRC_W          = $clog2(NUM_SUB + 1)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_AXIS-1:0]  axis_block_sigs,
   input  logic [NUM_IDLE-1:0]  inst_idle_sigs,
   input  logic [NUM_INST-1:0]  inst_block_sigs,
   input  logic [NUM_SUB-1:0]   sub_block,
   input  logic                 clear,
   output logic                 block,
   output logic                 block_confirmed,
   output logic                 block_sticky,
   output logic [SRC_W-1:0]     block_src,
   output logic [CYC_W-1:0]     block_cycles
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SUSPECT   = 2'd1,
      CONFIRMED = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] PERSIST = CNT_W'(PERSIST_CYCLES);
   localparam logic [SRC_W-1:0] OWN_SRC = SRC_W'(NUM_SUB);

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_next;
   logic [CNT_W-1:0]   cnt_inc;
   logic [NUM_SUB-1:0] sub_term;
   logic               own_term;
   logic               raw_hit;
   logic [SRC_W-1:0]   src_sel;
   logic               unused_inputs;

   // Instance idle/block flags only travel through the hierarchy to the children.
   assign unused_inputs = ^{inst_idle_sigs, inst_block_sigs};

   // A child counts only when it is blocked on a channel that is actually stalled here.
   for (genvar gi = 0; gi < NUM_SUB; gi++) begin : g_sub_term
      assign sub_term[gi] = sub_block[gi]
                          & (|(axis_block_sigs & SUB_AXIS_MASK[gi*NUM_AXIS +: NUM_AXIS]));
   end

   assign own_term = |(axis_block_sigs & CUR_AXIS_MASK);
   assign raw_hit  = (|sub_term) | own_term;
   assign cnt_inc  = cnt + CNT_W'(1);

   // Lowest contributing child wins; own channels are reported only when no child is.
   always_comb begin
      src_sel = OWN_SRC;
      for (int i = NUM_SUB - 1; i >= 0; i--) begin
         if (sub_term[i]) begin
            src_sel = SRC_W'(i);
         end
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (raw_hit) begin
               cnt_next   = CNT_W'(1);
               state_next = (PERSIST_CYCLES == 1) ? CONFIRMED : SUSPECT;
            end
         end
         SUSPECT: begin
            if (!raw_hit) begin
               cnt_next   = '0;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_inc;
               if (cnt_inc == PERSIST) begin
                  state_next = CONFIRMED;
               end
            end
         end
         CONFIRMED: begin
            if (!raw_hit) begin
               cnt_next   = '0;
               state_next = IDLE;
            end
         end
         default: begin
            cnt_next   = '0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         cnt             <= '0;
         block           <= 1'b0;
         block_confirmed <= 1'b0;
         block_sticky    <= 1'b0;
         block_src       <= '0;
         block_cycles    <= '0;
      end else begin
         state           <= state_next;
         cnt             <= cnt_next;
         block           <= raw_hit;
         block_confirmed <= (state_next == CONFIRMED);
         // clear beats set/increment; the FSM itself keeps running through a clear.
         if (clear) begin
            block_sticky <= 1'b0;
            block_src    <= '0;
            block_cycles <= '0;
         end else if (state_next == CONFIRMED) begin
            block_sticky <= 1'b1;
            if (!block_sticky) begin
               block_src <= src_sel;
            end
            if (block_cycles != {CYC_W{1'b1}}) begin
               block_cycles <= block_cycles + CYC_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_hls_deadlock_monitor_param.sv
// Directed bench for hls_deadlock_monitor_param: persistence filter, sticky/source
// reporting, clear priority, asynchronous reset and duration saturation.
module tb_hls_deadlock_monitor_param;

   logic        clock = 1'b0;
   logic        rst_n;
   logic [7:0]  axis_a, axis_b;
   logic [1:0]  sub_a, sub_b;
   logic        clear_a, clear_b;
   logic [18:0] idle_sigs;
   logic [10:0] inst_sigs;

   logic        a_block, a_conf, a_sticky;
   logic [1:0]  a_src;
   logic [31:0] a_cyc;
   logic        b_block, b_conf, b_sticky;
   logic [1:0]  b_src;
   logic [3:0]  b_cyc;
   logic        c_block, c_conf, c_sticky;
   logic [1:0]  c_src;
   logic [31:0] c_cyc;

   int n_vec = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   // Children: slice0 = 8'h18, slice1 = 8'h60; own channel 8'h80; four-cycle filter.
   hls_deadlock_monitor_param #(
      .SUB_AXIS_MASK(16'h6018), .CUR_AXIS_MASK(8'h80), .PERSIST_CYCLES(4)
   ) dut_a (
      .clock(clock), .reset(rst_n), .axis_block_sigs(axis_a), .inst_idle_sigs(idle_sigs),
      .inst_block_sigs(inst_sigs), .sub_block(sub_a), .clear(clear_a),
      .block(a_block), .block_confirmed(a_conf), .block_sticky(a_sticky),
      .block_src(a_src), .block_cycles(a_cyc)
   );

   // Own channel 8'h01, immediate confirmation, 4-bit duration counter.
   hls_deadlock_monitor_param #(
      .SUB_AXIS_MASK(16'h6018), .CUR_AXIS_MASK(8'h01), .PERSIST_CYCLES(1), .CYC_W(4)
   ) dut_b (
      .clock(clock), .reset(rst_n), .axis_block_sigs(axis_b), .inst_idle_sigs(idle_sigs),
      .inst_block_sigs(inst_sigs), .sub_block(sub_b), .clear(clear_b),
      .block(b_block), .block_confirmed(b_conf), .block_sticky(b_sticky),
      .block_src(b_src), .block_cycles(b_cyc)
   );

   // All-zero masks, sharing dut_a's stimulus: must never report anything.
   hls_deadlock_monitor_param #(
      .PERSIST_CYCLES(4)
   ) dut_c (
      .clock(clock), .reset(rst_n), .axis_block_sigs(axis_a), .inst_idle_sigs(idle_sigs),
      .inst_block_sigs(inst_sigs), .sub_block(sub_a), .clear(clear_a),
      .block(c_block), .block_confirmed(c_conf), .block_sticky(c_sticky),
      .block_src(c_src), .block_cycles(c_cyc)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic clear_a_pulse();
      clear_a = 1'b1;
      step(1);
      clear_a = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      axis_a = '0; axis_b = '0; sub_a = '0; sub_b = '0;
      clear_a = 1'b0; clear_b = 1'b0;
      idle_sigs = 19'h5a5a5; inst_sigs = 11'h3c3;
      step(2);
      check("rst block",  32'(a_block),  0);
      check("rst conf",   32'(a_conf),   0);
      check("rst sticky", 32'(a_sticky), 0);
      check("rst src",    32'(a_src),    0);
      check("rst cycles", a_cyc,         0);
      rst_n = 1'b1;
      step(1);

      // P=1 own channel: confirms one edge after onset, then counts and saturates at 15.
      axis_b = 8'h01;
      step(1);
      check("b conf",    32'(b_conf),  1);
      check("b block",   32'(b_block), 1);
      check("b src own", 32'(b_src),   2);
      check("b cyc1",    32'(b_cyc),   1);
      step(1);
      check("b cyc2",    32'(b_cyc),   2);
      step(1);
      check("b cyc3",    32'(b_cyc),   3);
      step(17);
      check("b cyc sat", 32'(b_cyc),   15);
      axis_b = 8'h00;
      step(1);
      check("b conf drop", 32'(b_conf), 0);
      check("b cyc hold",  32'(b_cyc),  15);
      clear_b = 1'b1;
      step(1);
      clear_b = 1'b0;
      check("b cyc clr",    32'(b_cyc),    0);
      check("b sticky clr", 32'(b_sticky), 0);

      // Child 0 blocked on 8'h08 for four cycles.
      sub_a = 2'b01; axis_a = 8'h08;
      step(1);
      check("t1 block",     32'(a_block), 1);
      check("t1 conf e1",   32'(a_conf),  0);
      check("t1 zero mask", 32'(c_block), 0);
      step(2);
      check("t1 conf e3",   32'(a_conf),  0);
      step(1);
      check("t1 conf e4",   32'(a_conf),   1);
      check("t1 sticky",    32'(a_sticky), 1);
      check("t1 src",       32'(a_src),    0);
      check("t1 cycles",    a_cyc,         1);
      axis_a = 8'h00;
      step(1);
      check("t1 conf drop", 32'(a_conf),   0);
      check("t1 blk drop",  32'(a_block),  0);
      check("t1 sticky hd", 32'(a_sticky), 1);
      check("t1 cyc hold",  a_cyc,         1);
      clear_a_pulse();
      check("t1 sticky clr", 32'(a_sticky), 0);
      check("t1 cyc clr",    a_cyc,         0);

      // Interrupted hit: 3 on, 1 off, 3 on never confirms; a 4th consecutive hit does.
      axis_a = 8'h08;
      step(3);
      check("t2 conf a", 32'(a_conf), 0);
      axis_a = 8'h00;
      step(1);
      axis_a = 8'h08;
      step(3);
      check("t2 conf b",   32'(a_conf),   0);
      check("t2 sticky",   32'(a_sticky), 0);
      step(1);
      check("t2 conf 4th", 32'(a_conf),   1);
      axis_a = 8'h00;
      clear_a_pulse();

      // Child 1 for 10 cycles, drop, clear five cycles later.
      sub_a = 2'b10; axis_a = 8'h20;
      step(10);
      check("t4 conf",   32'(a_conf), 1);
      check("t4 src",    32'(a_src),  1);
      check("t4 cycles", a_cyc,       7);
      axis_a = 8'h00;
      step(1);
      check("t4 conf drop", 32'(a_conf),   0);
      step(4);
      check("t4 sticky hd", 32'(a_sticky), 1);
      check("t4 src hd",    32'(a_src),    1);
      check("t4 cyc hd",    a_cyc,         7);
      clear_a_pulse();
      check("t4 sticky clr", 32'(a_sticky), 0);
      check("t4 src clr",    32'(a_src),    0);
      check("t4 cyc clr",    a_cyc,         0);

      // Own channel, then clear while still confirmed.
      sub_a = 2'b00; axis_a = 8'h80;
      step(4);
      check("t5 src own", 32'(a_src), 2);
      step(2);
      check("t5 cyc3",    a_cyc,       3);
      clear_a_pulse();
      check("t5 clr sticky", 32'(a_sticky), 0);
      check("t5 clr cyc",    a_cyc,         0);
      check("t5 clr conf",   32'(a_conf),   1);
      step(1);
      check("t5 re sticky", 32'(a_sticky), 1);
      check("t5 re cyc",    a_cyc,         1);
      check("t5 re src",    32'(a_src),    2);
      axis_a = 8'h00;
      step(1);
      clear_a_pulse();

      // Both children at once -> child 0; child 1 plus own -> child 1.
      sub_a = 2'b11; axis_a = 8'h28;
      step(4);
      check("t6 src both", 32'(a_src), 0);
      axis_a = 8'h00;
      step(1);
      clear_a_pulse();
      sub_a = 2'b10; axis_a = 8'ha0;
      step(4);
      check("t6 src c1own", 32'(a_src), 1);
      axis_a = 8'h00;
      step(1);
      clear_a_pulse();

      // Asynchronous reset in SUSPECT (cnt=3), then a full filter period again.
      sub_a = 2'b01; axis_a = 8'h08;
      step(3);
      #2 rst_n = 1'b0;
      #1;
      check("t7 async block", 32'(a_block), 0);
      check("t7 async conf",  32'(a_conf),  0);
      @(negedge clock);
      rst_n = 1'b1;
      step(3);
      check("t7 conf e3", 32'(a_conf), 0);
      step(1);
      check("t7 conf e4", 32'(a_conf),   1);
      check("t7 sticky",  32'(a_sticky), 1);
      axis_a = 8'h00;
      step(1);
      clear_a_pulse();

      check("c conf",   32'(c_conf),   0);
      check("c sticky", 32'(c_sticky), 0);
      check("c src",    32'(c_src),    0);
      check("c cycles", c_cyc,         0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
